// File: rtl/mem_arbiter_rr.sv
// Round-robin (or fixed-priority) arbiter from N line-granular cache clients onto one
// downstream line port; one transaction in flight, all downstream-facing outputs registered.
module mem_arbiter_rr #(
  parameter int N_PORTS  = 2,
  parameter int S_OFFSET = 5,
  parameter int S_LINE   = 256,
  parameter int ADDR_W   = 32,
  parameter int RR_MODE  = 1,
  parameter int ID_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PORTS-1:0]         up_read,
  input  logic [N_PORTS-1:0]         up_write,
  input  logic [N_PORTS*ADDR_W-1:0]  up_address,
  input  logic [N_PORTS*S_LINE-1:0]  up_wdata,
  output logic [N_PORTS-1:0]         up_resp,
  output logic [S_LINE-1:0]          up_rdata,
  output logic                       dn_read,
  output logic                       dn_write,
  output logic [ADDR_W-1:0]          dn_address,
  output logic [S_LINE-1:0]          dn_wdata,
  input  logic                       dn_resp,
  input  logic [S_LINE-1:0]          dn_rdata,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << S_OFFSET;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [N_PORTS-1:0] req;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic [ID_W:0]      scan_sum;
  logic [ID_W-1:0]    scan_id;
  logic [ID_W:0]      ptr_inc;
  logic [ID_W-1:0]    ptr_next;
  logic [ADDR_W-1:0]  addr_a  [N_PORTS];
  logic [S_LINE-1:0]  wdata_a [N_PORTS];

  function automatic logic [N_PORTS-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot     = '0;
    id_onehot[id] = 1'b1;
  endfunction

  assign req  = up_read | up_write;
  assign busy = (state != IDLE);

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      addr_a[i]  = up_address[i*ADDR_W +: ADDR_W];
      wdata_a[i] = up_wdata[i*S_LINE +: S_LINE];
    end
  end

  // Scan clients starting at rr_ptr (or at 0 in fixed-priority mode), wrapping once.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    scan_sum = '0;
    scan_id  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (RR_MODE != 0) scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      else              scan_sum = (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(N_PORTS)) scan_sum = scan_sum - (ID_W+1)'(N_PORTS);
      scan_id = scan_sum[ID_W-1:0];
      if (!win_vld && req[scan_id]) begin
        win_vld = 1'b1;
        win_id  = scan_id;
      end
    end
  end

  assign ptr_inc  = {1'b0, grant_id} + (ID_W+1)'(1);
  assign ptr_next = (ptr_inc == (ID_W+1)'(N_PORTS)) ? '0 : ptr_inc[ID_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      up_resp    <= '0;
      up_rdata   <= '0;
      dn_read    <= 1'b0;
      dn_write   <= 1'b0;
      dn_address <= '0;
      dn_wdata   <= '0;
    end else begin
      up_resp <= '0;
      case (state)
        // Grant: capture the winner's request so it may drop it while in flight.
        IDLE: begin
          if (win_vld) begin
            grant_id   <= win_id;
            dn_write   <= up_write[win_id];
            dn_read    <= ~up_write[win_id];
            dn_address <= addr_a[win_id] & LINE_MASK;
            dn_wdata   <= wdata_a[win_id];
            state      <= BUSY;
          end
        end
        // Downstream transfer: hold request stable until the completion arrives.
        BUSY: begin
          if (dn_resp) begin
            if (dn_read) up_rdata <= dn_rdata;
            dn_read  <= 1'b0;
            dn_write <= 1'b0;
            up_resp  <= id_onehot(grant_id);
            state    <= DONE;
          end
        end
        // Completion pulse is visible this cycle; requests are not sampled here.
        DONE: begin
          if (RR_MODE != 0) rr_ptr <= ptr_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
